// File: rtl/conv_scheduler.sv
// conv_scheduler: hands output channels round-robin to idle conv units, then streams each unit's input-row windows.
// Latency: command accepted at T -> unit_start at T+1 -> first row_valid at T+2; layer_done one cycle after the last unit_done.
// Backpressure: row_ready stalls only that unit's stream (addr/last held); cmd_ready is low for the whole layer.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_valid/cmd_ready + cmd_*      layer command (channels, rows, kernel, stride, parallel mode)
//   unit_start, unit_chan, unit_par  per-unit channel assignment pulse, channel index, layer parallel mode
//   row_valid/row_ready, row_addr,   per-unit window-start row stream; row_last flags a channel's final window
//   row_last
//   unit_done                        per-unit channel completion pulse
//   layer_done                       one-cycle pulse when every channel of the layer has completed
module conv_scheduler #(
    parameter int CONVUNITS = 2,
    parameter int CH_BITS   = 10,
    parameter int ROW_BITS  = 6,
    parameter int KER_W     = 3,
    parameter int STR_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CH_BITS-1:0]            cmd_channels,
    input  logic [ROW_BITS-1:0]           cmd_rows,
    input  logic [KER_W-1:0]              cmd_kernel,
    input  logic [STR_W-1:0]              cmd_stride,
    input  logic [1:0]                    cmd_par,
    output logic [CONVUNITS-1:0]          unit_start,
    output logic [CH_BITS-1:0]            unit_chan,
    output logic [1:0]                    unit_par,
    output logic [CONVUNITS-1:0]          row_valid,
    input  logic [CONVUNITS-1:0]          row_ready,
    output logic [CONVUNITS*ROW_BITS-1:0] row_addr,
    output logic [CONVUNITS-1:0]          row_last,
    input  logic [CONVUNITS-1:0]          unit_done,
    output logic                          layer_done
);
    localparam int PTR_W = (CONVUNITS > 1) ? $clog2(CONVUNITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN} state_t;
    typedef enum logic [1:0] {U_IDLE, U_ROWS, U_WAIT} ustate_t;

    // Layer-level state
    state_t              state_q, state_d;
    logic [CH_BITS-1:0]  chan_q, chan_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic                ld_q, ld_d;
    logic                lat_en;

    // Latched command
    logic [CH_BITS-1:0]  ch_q;
    logic [ROW_BITS-1:0] nout_q;
    logic [ROW_BITS-1:0] stride_q;
    logic [1:0]          par_q;

    // Per-unit state
    ustate_t             u_q [CONVUNITS];
    ustate_t             u_d [CONVUNITS];
    logic [ROW_BITS-1:0] k_q [CONVUNITS];
    logic [ROW_BITS-1:0] k_d [CONVUNITS];
    logic [ROW_BITS-1:0] a_q [CONVUNITS];
    logic [ROW_BITS-1:0] a_d [CONVUNITS];

    // Command decode: window count and effective stride are computed once at accept
    logic [ROW_BITS-1:0] ker_ext, str_ext, nout_calc;
    logic                degenerate;

    always_comb begin
        ker_ext    = ROW_BITS'(cmd_kernel);
        str_ext    = (cmd_stride == '0) ? ROW_BITS'(1) : ROW_BITS'(cmd_stride);
        degenerate = (cmd_channels == '0) || (cmd_rows < ker_ext);
        // Wraps for degenerate commands, but nout is never used in that case
        nout_calc  = (cmd_rows - ker_ext) / str_ext + ROW_BITS'(1);
    end

    // Round-robin pick of the first idle unit at or after rr_q. A unit freed by
    // unit_done this cycle is still in U_WAIT, so it only becomes eligible next cycle.
    logic [CONVUNITS-1:0] u_idle;
    logic                 pick_vld;
    logic [PTR_W-1:0]     pick;

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < CONVUNITS; i++) begin
            if (!pick_vld && u_idle[(int'(rr_q) + i) % CONVUNITS]) begin
                pick_vld = 1'b1;
                pick     = PTR_W'((int'(rr_q) + i) % CONVUNITS);
            end
        end
    end

    // True when every unit will be idle next cycle, counting units released by unit_done now
    logic all_idle_next;

    always_comb begin
        all_idle_next = 1'b1;
        for (int u = 0; u < CONVUNITS; u++) begin
            if (!((u_q[u] == U_IDLE) || ((u_q[u] == U_WAIT) && unit_done[u]))) begin
                all_idle_next = 1'b0;
            end
        end
    end

    // Top FSM. unit_start depends only on registered state, never on inputs in the same cycle.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        rr_d       = rr_q;
        ld_d       = 1'b0;
        lat_en     = 1'b0;
        unit_start = '0;
        unit_chan  = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    lat_en  = 1'b1;
                    chan_d  = '0;
                    // Each layer's dispatch starts from unit 0
                    rr_d    = '0;
                    state_d = degenerate ? S_DRAIN : S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (pick_vld) begin
                    unit_start[pick] = 1'b1;
                    unit_chan        = chan_q;
                    chan_d           = chan_q + CH_BITS'(1);
                    rr_d             = PTR_W'((int'(pick) + 1) % CONVUNITS);
                    if (chan_q == ch_q - CH_BITS'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // layer_done is registered; hold DRAIN through its pulse so
                // cmd_ready rises only in the following cycle
                if (ld_q) begin
                    state_d = S_IDLE;
                end else if (all_idle_next) begin
                    ld_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            chan_q   <= '0;
            rr_q     <= '0;
            ld_q     <= 1'b0;
            ch_q     <= '0;
            nout_q   <= '0;
            stride_q <= '0;
            par_q    <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            rr_q    <= rr_d;
            ld_q    <= ld_d;
            if (lat_en) begin
                ch_q     <= cmd_channels;
                nout_q   <= nout_calc;
                stride_q <= str_ext;
                par_q    <= cmd_par;
            end
        end
    end

    // Per-unit FSMs. The address is accumulated by stride rather than multiplied.
    always_comb begin
        for (int u = 0; u < CONVUNITS; u++) begin
            u_d[u] = u_q[u];
            k_d[u] = k_q[u];
            a_d[u] = a_q[u];
            case (u_q[u])
                U_IDLE: begin
                    if (unit_start[u]) begin
                        u_d[u] = U_ROWS;
                        k_d[u] = '0;
                        a_d[u] = '0;
                    end
                end
                U_ROWS: begin
                    if (row_ready[u]) begin
                        if (k_q[u] == nout_q - ROW_BITS'(1)) begin
                            u_d[u] = U_WAIT;
                        end else begin
                            k_d[u] = k_q[u] + ROW_BITS'(1);
                            a_d[u] = a_q[u] + stride_q;
                        end
                    end
                end
                U_WAIT: begin
                    if (unit_done[u]) begin
                        u_d[u] = U_IDLE;
                    end
                end
                default: u_d[u] = U_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int u = 0; u < CONVUNITS; u++) begin
            if (!rst_n) begin
                u_q[u] <= U_IDLE;
                k_q[u] <= '0;
                a_q[u] <= '0;
            end else begin
                u_q[u] <= u_d[u];
                k_q[u] <= k_d[u];
                a_q[u] <= a_d[u];
            end
        end
    end

    // Row outputs are forced to zero outside U_ROWS so idle lanes read clean
    always_comb begin
        u_idle    = '0;
        row_valid = '0;
        row_last  = '0;
        row_addr  = '0;
        for (int u = 0; u < CONVUNITS; u++) begin
            u_idle[u]    = (u_q[u] == U_IDLE);
            row_valid[u] = (u_q[u] == U_ROWS);
            row_last[u]  = (u_q[u] == U_ROWS) && (k_q[u] == nout_q - ROW_BITS'(1));
            row_addr[u*ROW_BITS +: ROW_BITS] = (u_q[u] == U_ROWS) ? a_q[u] : '0;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign unit_par   = par_q;
    assign layer_done = ld_q;

endmodule

// File: doc/conv_scheduler.md
# conv_scheduler

Layer-level scheduler for the convolution units. It accepts one layer command (output channels, input rows, kernel size, stride, parallel mode). It hands output channels round-robin to idle convolution units, then steps each busy unit through its input-row windows over a valid/ready row interface. When every channel is complete it signals layer completion. It sits between the layer controller and the CONVUNITS convolution-unit instances.

## Interface
**Parameters**
- CONVUNITS, 2, number of convolution units scheduled.
- CH_BITS, 10, width of the channel count and channel index.
- ROW_BITS, 6, width of row counts and row addresses (must hold CONV_SIZE_MAX + kernel).
- KER_W, 3, width of the kernel-size field.
- STR_W, 2, width of the stride field.

**Ports**
- clk, input, 1, single clock; all logic is rising-edge.
- rst_n, input, 1, synchronous active-low reset.
- cmd_valid, input, 1, layer command valid.
- cmd_ready, output, 1, scheduler idle and able to accept a command.
- cmd_channels, input, CH_BITS, number of output channels.
- cmd_rows, input, ROW_BITS, number of input rows.
- cmd_kernel, input, KER_W, kernel size.
- cmd_stride, input, STR_W, stride; 0 is treated as 1.
- cmd_par, input, 2, parallel-mode index 0..2, forwarded to the units.
- unit_start, output, CONVUNITS, one-hot, 1-cycle pulse assigning a channel.
- unit_chan, output, CH_BITS, channel index; valid with unit_start.
- unit_par, output, 2, parallel mode latched for the whole layer.
- row_valid, output, CONVUNITS, per-unit row command valid.
- row_ready, input, CONVUNITS, per-unit row command accept.
- row_addr, output, CONVUNITS×ROW_BITS, per-unit window start row.
- row_last, output, CONVUNITS, marks the final window of a channel.
- unit_done, input, CONVUNITS, unit finished its channel; 1-cycle pulse.
- layer_done, output, 1, 1-cycle pulse when the layer completes.

## Operation
**Top FSM: IDLE → DISPATCH → DRAIN → IDLE**
- IDLE (the reset state):
  - cmd_ready = 1.
  - When cmd_valid && cmd_ready, latch all command fields.
  - Compute nout = (rows − kernel)/stride_eff + 1, where stride_eff = stride, or 1 if stride = 0.
  - If channels = 0 or rows < kernel, this is a degenerate command: go straight to DRAIN with no unit activity.
  - Otherwise go to DISPATCH.
- DISPATCH:
  - At most one channel is assigned per cycle.
  - The target is the first idle unit, searching from rr_ptr upward with wrap.
  - On assignment: pulse unit_start[u], drive unit_chan = chan_cnt, then chan_cnt++ and rr_ptr = u+1 (mod CONVUNITS).
  - Move to DRAIN once chan_cnt reaches channels.
- DRAIN: when all units are idle, pulse layer_done and return to IDLE.

**Per-unit FSM: U_IDLE → U_ROWS → U_WAIT → U_IDLE**
- U_ROWS:
  - row_valid = 1 and row_addr = k·stride_eff, for k = 0..nout−1.
  - row_last = 1 when k = nout−1.
  - k advances on row_valid && row_ready.
- U_WAIT: entered after the handshake on the last row; leave on unit_done.
- unit_done is ignored in U_IDLE and U_ROWS.
- A unit can receive its next unit_start no earlier than the cycle after it leaves U_WAIT.

**Arithmetic**
- Row addresses are unsigned ROW_BITS values.
- The largest address issued is (nout−1)·stride_eff ≤ rows − kernel, so no overflow occurs.

## Timing
- **Reset:** synchronous, active-low.
  - All FSMs return to IDLE / U_IDLE.
  - cmd_ready = 1 from the first cycle after reset.
  - All other outputs are 0: unit_start, unit_chan, unit_par, row_valid, row_addr, row_last, layer_done.
  - Reset mid-layer abandons the layer silently; layer_done is not asserted.
- **Command accept:** handshake at cycle T; cmd_ready = 0 from T+1.
- **First assignment:** unit_start is registered and appears at T+1; that unit's row_valid rises at T+2.
- **Row stream:** back-to-back rows are allowed. row_valid stays high and row_addr updates in the cycle after each accepted handshake.
- **Held outputs:** row_addr and row_last are stable while row_valid && !row_ready.
- **Simultaneous events:** a unit's unit_done and another unit's assignment in the same cycle are both honoured. The freed unit is not eligible until the next cycle.
- **Layer completion:** layer_done is asserted one cycle after the last unit_done (or at T+2 for a degenerate command). cmd_ready returns high in the cycle after layer_done.
- **Ignored input:** cmd_valid while cmd_ready = 0 is ignored.

## Test plan
1. **Single window stream:** channels=1, rows=31, kernel=5, stride=1, with row_ready held high.
   - unit 0 receives chan 0 at T+1.
   - 27 rows are issued, addresses 0..26, on consecutive cycles; row_last is asserted with address 26.
   - unit_done → layer_done one cycle later.
2. **Stride 2:** rows=31, kernel=5, stride=2.
   - Exactly 14 rows are issued, addresses 0,2,…,26; row_last is on address 26.
3. **Round-robin dispatch:** channels=5 with 2 units, and unit_done returned 3 cycles after each unit's last row.
   - Assignment order is u0:0, u1:1, u0:2, u1:3, u0:4.
   - layer_done is asserted only after both units finish.
4. **Backpressure:** row_ready toggled randomly on unit 1.
   - row_addr and row_last stay stable while stalled.
   - No address is skipped or duplicated, and unit 0 proceeds independently.
5. **Degenerate commands and stride 0:**
   - channels=0 → layer_done at T+2 with no unit_start.
   - rows=4, kernel=5 → same result.
   - stride=0 → stride 1 behaviour.
6. **Reset mid-layer:** rst_n=0 during row 10 of channel 3.
   - Next cycle: all outputs are at their reset values and cmd_ready=1.
   - A new command then runs cleanly from channel 0.
